sif_modport: RTL and testbench
==============================

Name: sif_modport

Overview:
- System-interface (SIF) slave block.
- Accepts register reads and writes from a host-side "xa" port and keeps them in a local register file.
- Forwards every accepted host write, unchanged, onto a write-only "wa" port toward the downstream block.
- Sits between the host bus agent and the downstream write sink; the verification scoreboard expects a 1:1 match of xa writes to wa writes.

Parameters:
- DW, 16, data width of xa_data_wr, xa_data_rd and wa_data_wr.
- AW, 16, address width of xa_addr and wa_addr.
- NREGS, 16, number of local registers; 1..256, power of two.
- BASE_ADDR, 16'h0000, address of register 0. Register i sits at BASE_ADDR+i.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- xa_addr, input, AW, host address, sampled when a strobe is high.
- xa_data_wr, input, DW, host write data.
- xa_wr_s, input, 1, host write strobe; single-cycle, one transfer per high cycle.
- xa_rd_s, input, 1, host read strobe; single-cycle, one transfer per high cycle.
- xa_data_rd, output, DW, host read data, registered.
- wa_addr, output, AW, forwarded write address, registered.
- wa_data_wr, output, DW, forwarded write data, registered.
- wa_wr_s, output, 1, forwarded write strobe, registered.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All NREGS registers clear to 0.
  - xa_data_rd, wa_addr, wa_data_wr and wa_wr_s clear to 0.
  - A write sampled in the cycle reset asserts is dropped: no wa pulse, no register update.
- In-range test: BASE_ADDR <= xa_addr < BASE_ADDR+NREGS. Index = xa_addr-BASE_ADDR, computed in AW bits with no wrap. An address that overflows past 2^AW is out of range.
- Write, xa_wr_s=1 sampled at edge N:
  - If in range, reg[index] <= xa_data_wr at edge N.
  - Regardless of range, at edge N: wa_wr_s <= 1, wa_addr <= xa_addr, wa_data_wr <= xa_data_wr. The wa pulse is therefore visible during cycle N+1.
  - Latency: 1 cycle. Every xa write yields exactly one wa write with identical addr/data, in order.
  - Back-to-back xa writes yield back-to-back wa pulses. No stall, no backpressure.
- No write sampled at an edge: wa_wr_s <= 0 at that edge. wa_addr and wa_data_wr hold their last values.
- Read, xa_rd_s=1 sampled at edge N:
  - xa_data_rd <= reg[index] at edge N if in range, else 16'h0000. Valid during cycle N+1.
  - Without a read, xa_data_rd holds its last value.
  - Reads never touch the wa port.
- Simultaneous xa_wr_s and xa_rd_s:
  - The write is performed and forwarded.
  - The read returns the pre-write contents, unless SIF_RD_BYPASS_EN is defined (see below).
- Strobes are ignored while rst_n is low. The first edge after release processes strobes normally.
- No FSM. Datapath is a register file plus one forwarding pipeline stage.

Optional Feature:
- Macro: SIF_RD_BYPASS_EN.
- Defined: for simultaneous xa_wr_s and xa_rd_s to the same in-range address, xa_data_rd returns the new xa_data_wr (write-first).
- Not defined: xa_data_rd returns the old register value (read-first).
- The wa forwarding behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles, then release -> all outputs 0; reading registers 0..15 returns 16'h0000.
- Single write: xa_wr_s=1, addr=16'h0003, data=16'hA5A5 -> next cycle wa_wr_s=1, wa_addr=16'h0003, wa_data_wr=16'hA5A5; the following cycle wa_wr_s=0. Then a read of 16'h0003 returns 16'hA5A5 one cycle after the strobe.
- Burst: 8 back-to-back writes, addr 0..7, data 16'h1000+i -> 8 consecutive wa pulses, same order and values. Reads return the matching data.
- Out of range: write addr=16'h0040, data=16'hBEEF -> wa pulse carries 16'h0040/16'hBEEF. A read of 16'h0040 returns 16'h0000, and no in-range register changes.
- Collision: reg 5 holds 16'h1111; wr+rd same cycle to addr 5 with data 16'h2222 -> xa_data_rd=16'h1111 (16'h2222 with SIF_RD_BYPASS_EN); reg 5 ends at 16'h2222 in both builds.
- Mid-op reset: assert rst_n=0 in the same cycle a write strobe is sampled -> no wa pulse, target register stays 0.

Source files
------------

// File: rtl/sif_modport.sv
// -----------------------------------------------------------------------------
// sif_modport : system-interface slave with a local register file and a
// one-stage write-forwarding pipeline.
//
// Host reads and writes arrive on the "xa" port. In-range writes update the
// local register file. Every host write, in range or not, is replayed one
// cycle later on the write-only "wa" port with identical address and data.
//
// Ports
//   clk         in   1    single clock, posedge
//   rst_n       in   1    asynchronous active-low reset
//   xa_addr     in   AW   host address
//   xa_data_wr  in   DW   host write data
//   xa_wr_s     in   1    host write strobe (one transfer per high cycle)
//   xa_rd_s     in   1    host read strobe (one transfer per high cycle)
//   xa_data_rd  out  DW   host read data, registered, holds between reads
//   wa_addr     out  AW   forwarded write address, registered, holds
//   wa_data_wr  out  DW   forwarded write data, registered, holds
//   wa_wr_s     out  1    forwarded write strobe, registered, one-cycle pulse
//
// Build option
//   SIF_RD_BYPASS_EN : when defined, a read colliding with a write to the
//                      same in-range register returns the new write data
//                      (write-first). Default build is read-first.
// -----------------------------------------------------------------------------
module sif_modport #(
    parameter int             DW        = 16,
    parameter int             AW        = 16,
    parameter int             NREGS     = 16,
    parameter logic [AW-1:0]  BASE_ADDR = {AW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] xa_addr,
    input  logic [DW-1:0] xa_data_wr,
    input  logic          xa_wr_s,
    input  logic          xa_rd_s,
    output logic [DW-1:0] xa_data_rd,
    output logic [AW-1:0] wa_addr,
    output logic [DW-1:0] wa_data_wr,
    output logic          wa_wr_s
);

    // Index width; a single-register file still needs a one-bit index.
    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    // Range bounds are evaluated one bit wider than the address so that
    // BASE_ADDR+NREGS running past 2^AW never wraps back into range.
    localparam logic [AW:0] LO_BOUND = {1'b0, BASE_ADDR};
    localparam logic [AW:0] HI_BOUND = {1'b0, BASE_ADDR} + (AW+1)'(NREGS);

    logic [DW-1:0] regs_r [NREGS];

    logic [AW:0]   addr_ext_s;
    logic [AW:0]   offset_s;
    logic          in_range_s;
    logic [IW-1:0] index_s;
    logic [DW-1:0] rd_value_s;

    // Address decode: range test and register index.
    always_comb begin
        addr_ext_s = {1'b0, xa_addr};
        offset_s   = addr_ext_s - LO_BOUND;
        in_range_s = (addr_ext_s >= LO_BOUND) && (addr_ext_s < HI_BOUND);
        index_s    = offset_s[IW-1:0];
    end

    // Read data selection, including the optional write-first bypass.
    always_comb begin
        rd_value_s = {DW{1'b0}};
        if (in_range_s) begin
`ifdef SIF_RD_BYPASS_EN
            if (xa_wr_s) begin
                rd_value_s = xa_data_wr;
            end else begin
                rd_value_s = regs_r[index_s];
            end
`else
            rd_value_s = regs_r[index_s];
`endif
        end else begin
            rd_value_s = {DW{1'b0}};
        end
    end

    // Register file: in-range host writes land here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
        end else if (xa_wr_s && in_range_s) begin
            regs_r[index_s] <= xa_data_wr;
        end
    end

    // Host read data register; holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xa_data_rd <= {DW{1'b0}};
        end else if (xa_rd_s) begin
            xa_data_rd <= rd_value_s;
        end
    end

    // Forwarding stage: every host write becomes one wa pulse a cycle later;
    // address and data hold after the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wa_wr_s    <= 1'b0;
            wa_addr    <= {AW{1'b0}};
            wa_data_wr <= {DW{1'b0}};
        end else begin
            wa_wr_s <= xa_wr_s;
            if (xa_wr_s) begin
                wa_addr    <= xa_addr;
                wa_data_wr <= xa_data_wr;
            end
        end
    end

endmodule

// File: tb/tb_sif_modport.sv
// -----------------------------------------------------------------------------
// tb_sif_modport : directed bench for sif_modport.
// A behavioural model (register array plus last forwarded transfer) predicts
// the outputs; a compare process checks them on every falling edge, and the
// main sequence adds literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_sif_modport;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int NREGS = 16;
    localparam int BASE  = 0;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] xa_addr;
    logic [DW-1:0] xa_data_wr;
    logic          xa_wr_s;
    logic          xa_rd_s;
    logic [DW-1:0] xa_data_rd;
    logic [AW-1:0] wa_addr;
    logic [DW-1:0] wa_data_wr;
    logic          wa_wr_s;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    sif_modport dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .xa_addr    (xa_addr),
        .xa_data_wr (xa_data_wr),
        .xa_wr_s    (xa_wr_s),
        .xa_rd_s    (xa_rd_s),
        .xa_data_rd (xa_data_rd),
        .wa_addr    (wa_addr),
        .wa_data_wr (wa_data_wr),
        .wa_wr_s    (wa_wr_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_regs [NREGS];
    logic [DW-1:0] m_rd;
    logic          m_pulse;
    logic [AW-1:0] m_wa_addr;
    logic [DW-1:0] m_wa_data;

    always @(posedge clk or negedge rst_n) begin
        int a;
        bit hit;
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
            m_rd      = '0;
            m_pulse   = 1'b0;
            m_wa_addr = '0;
            m_wa_data = '0;
        end else begin
            a   = int'(xa_addr);
            hit = (a >= BASE) && (a < BASE + NREGS);
            if (xa_rd_s) begin
                if (!hit) m_rd = '0;
`ifdef SIF_RD_BYPASS_EN
                else if (xa_wr_s) m_rd = xa_data_wr;
`endif
                else m_rd = m_regs[a - BASE];
            end
            m_pulse = xa_wr_s;
            if (xa_wr_s) begin
                m_wa_addr = xa_addr;
                m_wa_data = xa_data_wr;
                if (hit) m_regs[a - BASE] = xa_data_wr;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_wa_wr_s",    32'(wa_wr_s),    32'(m_pulse));
            check("cmp_wa_addr",    32'(wa_addr),    32'(m_wa_addr));
            check("cmp_wa_data_wr", 32'(wa_data_wr), 32'(m_wa_data));
            check("cmp_xa_data_rd", 32'(xa_data_rd), 32'(m_rd));
        end
    end

    // Drive one cycle of strobes from a falling edge; returns at the next
    // falling edge, when the result of that cycle is visible.
    task automatic op(input logic w, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
        xa_wr_s    = w;
        xa_rd_s    = r;
        xa_addr    = a;
        xa_data_wr = d;
        @(negedge clk);
        xa_wr_s = 1'b0;
        xa_rd_s = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] coll_exp;
        rst_n      = 1'b1;
        xa_addr    = '0;
        xa_data_wr = '0;
        xa_wr_s    = 1'b0;
        xa_rd_s    = 1'b0;
        #1 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // Reset state.
        check("rst_wa_wr_s",    32'(wa_wr_s),    32'h0);
        check("rst_wa_addr",    32'(wa_addr),    32'h0);
        check("rst_wa_data_wr", 32'(wa_data_wr), 32'h0);
        check("rst_xa_data_rd", 32'(xa_data_rd), 32'h0);
        for (int i = 0; i < NREGS; i++) begin
            op(1'b0, 1'b1, 16'(i), 16'h0000);
            check("rst_read", 32'(xa_data_rd), 32'h0);
        end

        // Single write and read-back.
        op(1'b1, 1'b0, 16'h0003, 16'hA5A5);
        check("wr1_pulse", 32'(wa_wr_s),    32'h1);
        check("wr1_addr",  32'(wa_addr),    32'h0003);
        check("wr1_data",  32'(wa_data_wr), 32'hA5A5);
        op(1'b0, 1'b0, 16'h0000, 16'h0000);
        check("wr1_pulse_end", 32'(wa_wr_s),    32'h0);
        check("wr1_hold_data", 32'(wa_data_wr), 32'hA5A5);
        op(1'b0, 1'b1, 16'h0003, 16'h0000);
        check("rd1", 32'(xa_data_rd), 32'hA5A5);
        check("rd1_no_wa", 32'(wa_wr_s), 32'h0);

        // Burst of eight back-to-back writes.
        for (int i = 0; i < 8; i++) begin
            op(1'b1, 1'b0, 16'(i), 16'h1000 + 16'(i));
            check("burst_pulse", 32'(wa_wr_s),    32'h1);
            check("burst_addr",  32'(wa_addr),    32'(i));
            check("burst_data",  32'(wa_data_wr), 32'h1000 + 32'(i));
        end
        for (int i = 0; i < 8; i++) begin
            op(1'b0, 1'b1, 16'(i), 16'h0000);
            check("burst_read", 32'(xa_data_rd), 32'h1000 + 32'(i));
        end

        // Out-of-range writes and reads, including the boundaries.
        op(1'b1, 1'b0, 16'h0040, 16'hBEEF);
        check("oor_addr", 32'(wa_addr),    32'h0040);
        check("oor_data", 32'(wa_data_wr), 32'hBEEF);
        op(1'b0, 1'b1, 16'h0040, 16'h0000);
        check("oor_read", 32'(xa_data_rd), 32'h0000);
        op(1'b1, 1'b0, 16'h0010, 16'h5555);
        check("oor_edge_fwd", 32'(wa_data_wr), 32'h5555);
        op(1'b0, 1'b1, 16'h0010, 16'h0000);
        check("oor_edge_read", 32'(xa_data_rd), 32'h0000);
        op(1'b1, 1'b0, 16'h000F, 16'h0F0F);
        op(1'b0, 1'b1, 16'h000F, 16'h0000);
        check("top_reg_read", 32'(xa_data_rd), 32'h0F0F);
        op(1'b0, 1'b1, 16'hFFFF, 16'h0000);
        check("ffff_read", 32'(xa_data_rd), 32'h0000);
        op(1'b0, 1'b1, 16'h0000, 16'h0000);
        check("oor_no_alias", 32'(xa_data_rd), 32'h1000);

        // Read-write collision on register 5.
        op(1'b1, 1'b0, 16'h0005, 16'h1111);
        op(1'b1, 1'b1, 16'h0005, 16'h2222);
`ifdef SIF_RD_BYPASS_EN
        coll_exp = 16'h2222;
`else
        coll_exp = 16'h1111;
`endif
        check("coll_read", 32'(xa_data_rd), 32'(coll_exp));
        check("coll_fwd",  32'(wa_data_wr), 32'h2222);
        op(1'b0, 1'b1, 16'h0005, 16'h0000);
        check("coll_final", 32'(xa_data_rd), 32'h2222);

        // Reset asserted in the cycle a write is sampled.
        xa_wr_s    = 1'b1;
        xa_addr    = 16'h0009;
        xa_data_wr = 16'h7777;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_pulse", 32'(wa_wr_s), 32'h0);
        check("midrst_addr",  32'(wa_addr), 32'h0);
        xa_wr_s = 1'b0;
        rst_n   = 1'b1;
        op(1'b0, 1'b1, 16'h0009, 16'h0000);
        check("midrst_reg", 32'(xa_data_rd), 32'h0);
        op(1'b0, 1'b1, 16'h0005, 16'h0000);
        check("midrst_clear", 32'(xa_data_rd), 32'h0);
        op(1'b1, 1'b0, 16'h0002, 16'hCAFE);
        check("post_rst_fwd", 32'(wa_data_wr), 32'hCAFE);
        @(negedge clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
